multimode_counter: RTL and testbench

Parametrised successor to the team's generic wrap-around decade counter. Adds up/down counting, synchronous load/clear, a run-time terminal value, and three terminal behaviours: wrap, saturate and one-shot. Used as the building block for cascaded timing chains (prescalers, digit counters, timeouts), where TRIG_OUT of one stage drives ENABLE of the next.

---
 rtl/multimode_counter_pkg.sv | 25 ++
 rtl/multimode_counter_next_value.sv | 72 +++++++
 rtl/multimode_counter.sv | 104 ++++++++++
 tb/tb_multimode_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multimode_counter_pkg.sv
// -----------------------------------------------------------------------------
// multimode_counter_pkg
// Shared constants and types for the multimode counter slice.
//   MODE_*  : terminal-behaviour selector values carried on the MODE port.
//   state_t : 2-bit counter state (COUNTING / HELD / DONE). The fourth code
//             is unused and recovers to COUNTING on the next clock edge.
// -----------------------------------------------------------------------------
package multimode_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_COUNTING = 2'b00,
    ST_HELD     = 2'b01,
    ST_DONE     = 2'b10
  } state_t;

  // True for the three defined state codes.
  function automatic logic state_is_legal(input state_t s);
    return (s == ST_COUNTING) || (s == ST_HELD) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/multimode_counter_next_value.sv
// -----------------------------------------------------------------------------
// multimode_counter_next_value
// Combinational step logic: given the current count and state, works out what
// one enabled count step produces.
//   count      in  W  current registered count
//   dir        in  1  1 = up, 0 = down
//   mode       in  2  terminal behaviour (wrap / saturate / one-shot, 11 = wrap)
//   max_val    in  W  active terminal value
//   state      in  2  current state
//   next_count out W  count after the step
//   terminal   out 1  step reaches a terminal event that must pulse TRIG_OUT
//   next_state out 2  state after the step
// -----------------------------------------------------------------------------
module multimode_counter_next_value
  import multimode_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic                     dir,
  input  logic [1:0]               mode,
  input  logic [COUNTER_WIDTH-1:0] max_val,
  input  state_t                   state,
  output logic [COUNTER_WIDTH-1:0] next_count,
  output logic                     terminal,
  output state_t                   next_state
);

  logic                     at_term;
  logic [COUNTER_WIDTH-1:0] restart_val;

  always_comb begin
    // Up uses >= so that lowering MAX below the current count still
    // terminates on the next step instead of running on to 2^W.
    at_term     = dir ? (count >= max_val) : (count == '0);
    restart_val = dir ? '0 : max_val;
    next_count  = count;
    terminal    = 1'b0;
    next_state  = ST_COUNTING;

    case (state)
      ST_DONE: begin
        // One-shot finished: stepping is ignored until LOAD/CLEAR/reset.
        next_state = ST_DONE;
      end
      ST_COUNTING, ST_HELD: begin
        if (!at_term) begin
          // Also the exit from HELD when DIR points away from the terminal.
          next_count = dir ? count + 1'b1 : count - 1'b1;
          next_state = ST_COUNTING;
        end else if (mode == MODE_SAT) begin
          // Pulse only on entry to HELD, not on every cycle spent there.
          next_state = ST_HELD;
          terminal   = (state == ST_COUNTING);
        end else if (mode == MODE_ONESHOT) begin
          next_count = restart_val;
          next_state = ST_DONE;
          terminal   = 1'b1;
        end else begin
          // Wrap (MODE 00 and the spare code 11).
          next_count = restart_val;
          next_state = ST_COUNTING;
          terminal   = 1'b1;
        end
      end
      default: begin
        next_state = ST_COUNTING;
      end
    endcase
  end

endmodule

// File: rtl/multimode_counter.sv
// -----------------------------------------------------------------------------
// multimode_counter
// Up/down counter with synchronous clear/load, a fixed or run-time terminal
// value and wrap / saturate / one-shot terminal behaviours. TRIG_OUT of one
// stage is meant to drive ENABLE of the next in cascaded timing chains.
//   CLK        in  1  rising-edge clock
//   RESET_N    in  1  asynchronous active-low reset
//   ENABLE     in  1  count-step qualifier
//   DIR        in  1  1 = up, 0 = down
//   MODE       in  2  00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   CLEAR      in  1  synchronous clear (highest priority)
//   LOAD       in  1  synchronous load of LOAD_VALUE, clamped to MAX
//   LOAD_VALUE in  W  load value
//   MAX_VALUE  in  W  run-time terminal value (RUNTIME_MAX = 1 only)
//   COUNT      out W  registered count
//   TRIG_OUT   out 1  registered one-cycle terminal pulse
//   RUNNING    out 1  high while counting (not HELD, not DONE)
// -----------------------------------------------------------------------------
module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9,
  parameter int RUNTIME_MAX   = 0
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE,
  input  logic                     DIR,
  input  logic [1:0]               MODE,
  input  logic                     CLEAR,
  input  logic                     LOAD,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
  input  logic [COUNTER_WIDTH-1:0] MAX_VALUE,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic                     TRIG_OUT,
  output logic                     RUNNING
);

  localparam logic [COUNTER_WIDTH-1:0] FIXED_MAX = COUNTER_WIDTH'(COUNTER_MAX);

  // Loaded values above the terminal are clamped so the count never starts
  // outside the 0..MAX range.
  function automatic logic [COUNTER_WIDTH-1:0] sat_load(
    input logic [COUNTER_WIDTH-1:0] value,
    input logic [COUNTER_WIDTH-1:0] limit
  );
    return (value > limit) ? limit : value;
  endfunction

  logic [COUNTER_WIDTH-1:0] max_sel;
  logic [COUNTER_WIDTH-1:0] step_count;
  logic                     step_term;
  state_t                   step_state;

  logic [COUNTER_WIDTH-1:0] count_p1;
  logic                     trig_p1;
  state_t                   state_p1;

  assign max_sel = (RUNTIME_MAX != 0) ? MAX_VALUE : FIXED_MAX;

  multimode_counter_next_value #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_next_value (
    .count      (count_p1),
    .dir        (DIR),
    .mode       (MODE),
    .max_val    (max_sel),
    .state      (state_p1),
    .next_count (step_count),
    .terminal   (step_term),
    .next_state (step_state)
  );

  // ---- stage p1: count / trigger / state registers ----
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_p1 <= '0;
      trig_p1  <= 1'b0;
      state_p1 <= ST_COUNTING;
    end else if (CLEAR) begin
      count_p1 <= '0;
      trig_p1  <= 1'b0;
      state_p1 <= ST_COUNTING;
    end else if (LOAD) begin
      count_p1 <= sat_load(LOAD_VALUE, max_sel);
      trig_p1  <= 1'b0;
      state_p1 <= ST_COUNTING;
    end else if (ENABLE) begin
      count_p1 <= step_count;
      trig_p1  <= step_term;
      state_p1 <= step_state;
    end else begin
      // Idle edge: hold, but still scrub the unused state code.
      trig_p1  <= 1'b0;
      state_p1 <= state_is_legal(state_p1) ? state_p1 : ST_COUNTING;
    end
  end

  assign COUNT    = count_p1;
  assign TRIG_OUT = trig_p1;
  assign RUNNING  = (state_p1 == ST_COUNTING);

endmodule

// File: tb/tb_multimode_counter.sv
// -----------------------------------------------------------------------------
// tb_multimode_counter
// Drives two counters in parallel (fixed terminal 9, run-time terminal from
// MAX_VALUE) with directed and random stimulus. Expected outputs come from a
// behavioural model and travel through a queue to an independent monitor.
// -----------------------------------------------------------------------------
module tb_multimode_counter;

  logic       CLK;
  logic       RESET_N;
  logic       ENABLE;
  logic       DIR;
  logic [1:0] MODE;
  logic       CLEAR;
  logic       LOAD;
  logic [3:0] LOAD_VALUE;
  logic [3:0] MAX_VALUE;

  logic [3:0] count_fix, count_rt;
  logic       trig_fix, trig_rt;
  logic       run_fix, run_rt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] c0;
    logic       t0;
    logic       r0;
    logic [3:0] c1;
    logic       t1;
    logic       r1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Behavioural model, index 0 = fixed-max counter, 1 = run-time-max counter.
  int m_cnt[2];
  bit m_held[2];
  bit m_done[2];
  bit m_trig[2];

  multimode_counter #(
    .COUNTER_WIDTH (4),
    .COUNTER_MAX   (9),
    .RUNTIME_MAX   (0)
  ) u_fix (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .DIR        (DIR),
    .MODE       (MODE),
    .CLEAR      (CLEAR),
    .LOAD       (LOAD),
    .LOAD_VALUE (LOAD_VALUE),
    .MAX_VALUE  (MAX_VALUE),
    .COUNT      (count_fix),
    .TRIG_OUT   (trig_fix),
    .RUNNING    (run_fix)
  );

  multimode_counter #(
    .COUNTER_WIDTH (4),
    .COUNTER_MAX   (9),
    .RUNTIME_MAX   (1)
  ) u_rt (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .DIR        (DIR),
    .MODE       (MODE),
    .CLEAR      (CLEAR),
    .LOAD       (LOAD),
    .LOAD_VALUE (LOAD_VALUE),
    .MAX_VALUE  (MAX_VALUE),
    .COUNT      (count_rt),
    .TRIG_OUT   (trig_rt),
    .RUNNING    (run_rt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_held[k] = 1'b0;
      m_done[k] = 1'b0;
      m_trig[k] = 1'b0;
    end
  endtask

  // One clock edge of the counter, written from the behavioural rules.
  task automatic model_step(input int k, input bit clr, input bit ld, input bit en,
                            input bit dir, input int mode, input int ldv, input int mx);
    bit term;
    m_trig[k] = 1'b0;
    if (clr) begin
      m_cnt[k] = 0;  m_held[k] = 1'b0;  m_done[k] = 1'b0;
    end else if (ld) begin
      m_cnt[k] = (ldv > mx) ? mx : ldv;
      m_held[k] = 1'b0;  m_done[k] = 1'b0;
    end else if (en && !m_done[k]) begin
      term = dir ? (m_cnt[k] >= mx) : (m_cnt[k] == 0);
      if (!term) begin
        m_cnt[k] = dir ? m_cnt[k] + 1 : m_cnt[k] - 1;
        m_held[k] = 1'b0;
      end else if (mode == 1) begin
        if (!m_held[k]) m_trig[k] = 1'b1;
        m_held[k] = 1'b1;
      end else if (mode == 2) begin
        m_cnt[k] = dir ? 0 : mx;
        m_done[k] = 1'b1;
        m_trig[k] = 1'b1;
      end else begin
        m_cnt[k] = dir ? 0 : mx;
        m_held[k] = 1'b0;
        m_trig[k] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs and queue what both counters should show next.
  task automatic cyc(input bit clr, input bit ld, input bit en, input bit dir,
                     input int mode, input int ldv, input int mxv);
    exp_t e;
    @(negedge CLK);
    CLEAR      = clr;
    LOAD       = ld;
    ENABLE     = en;
    DIR        = dir;
    MODE       = 2'(mode);
    LOAD_VALUE = 4'(ldv);
    MAX_VALUE  = 4'(mxv);
    model_step(0, clr, ld, en, dir, mode, ldv, 9);
    model_step(1, clr, ld, en, dir, mode, ldv, mxv);
    e.c0 = 4'(m_cnt[0]);  e.t0 = m_trig[0];  e.r0 = !(m_held[0] || m_done[0]);
    e.c1 = 4'(m_cnt[1]);  e.t1 = m_trig[1];  e.r1 = !(m_held[1] || m_done[1]);
    exp_q.push_back(e);
  endtask

  // Monitor: every output update is checked against the oldest expectation.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("fix_count", 32'(count_fix), 32'(mon_e.c0));
      chk("fix_trig",  32'(trig_fix),  32'(mon_e.t0));
      chk("fix_run",   32'(run_fix),   32'(mon_e.r0));
      chk("rt_count",  32'(count_rt),  32'(mon_e.c1));
      chk("rt_trig",   32'(trig_rt),   32'(mon_e.t1));
      chk("rt_run",    32'(run_rt),    32'(mon_e.r1));
    end
  end

  initial begin
    int mxv;
    RESET_N = 1'b0;  ENABLE = 1'b0;  DIR = 1'b1;  MODE = 2'b00;
    CLEAR = 1'b0;  LOAD = 1'b0;  LOAD_VALUE = '0;  MAX_VALUE = 4'd9;
    model_reset();

    #12;
    chk("reset_count", 32'(count_fix), 32'd0);
    chk("reset_trig",  32'(trig_fix),  32'd0);
    chk("reset_run",   32'(run_fix),   32'd1);
    chk("reset_count_rt", 32'(count_rt), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Wrap up from reset: 1..9, 0 (pulse), 1, 2.
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0, 9);

    // Wrap down from 2: 1, 0, 9 (pulse), 8; then clamped load.
    cyc(0, 1, 0, 0, 0, 2, 9);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 9);
    cyc(0, 1, 0, 0, 0, 12, 9);

    // Saturate up from 7, then step back down out of HELD.
    cyc(0, 1, 0, 1, 1, 7, 9);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0, 9);
    cyc(0, 0, 1, 0, 1, 0, 9);
    cyc(0, 0, 1, 0, 1, 0, 9);

    // One-shot with run-time terminal 3, ENABLE ignored in DONE, load restarts.
    cyc(1, 0, 0, 1, 2, 0, 3);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 2, 0, 3);
    cyc(0, 1, 0, 1, 2, 1, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 2, 0, 3);

    // Terminal lowered below the current count.
    cyc(0, 1, 0, 1, 0, 7, 9);
    cyc(0, 0, 1, 1, 0, 0, 5);
    cyc(0, 0, 1, 1, 0, 0, 5);

    // Terminal of zero in wrap mode: stays 0 with TRIG_OUT every cycle.
    cyc(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle with COUNT=6, TRIG_OUT=1.
    cyc(0, 1, 0, 0, 0, 0, 6);
    cyc(0, 0, 1, 0, 0, 0, 6);
    @(posedge CLK);
    #3;
    chk("pre_reset_count", 32'(count_rt), 32'd6);
    chk("pre_reset_trig",  32'(trig_rt),  32'd1);
    RESET_N = 1'b0;
    #1;
    chk("async_count_rt", 32'(count_rt),  32'd0);
    chk("async_trig_rt",  32'(trig_rt),   32'd0);
    chk("async_count",    32'(count_fix), 32'd0);
    chk("async_trig",     32'(trig_fix),  32'd0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;

    // CLEAR wins over LOAD.
    cyc(0, 1, 0, 1, 0, 5, 9);
    cyc(1, 1, 1, 1, 0, 5, 9);

    // Random mix of all controls, with the run-time terminal changing now and then.
    mxv = 9;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mxv = $urandom_range(0, 15);
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), mxv);
    end

    @(posedge CLK);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
